// File: rtl/traffic_pkg.sv
// Default timing constants shared by the traffic-light timebase and the FSM top level.
package traffic_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int LONG_SECS       = 10;
  localparam int DEBOUNCE_CYCLES = 1_000_000;

endpackage : traffic_pkg

// File: rtl/traffic_timer_ped_debounce.sv
// Pedestrian button conditioning: two-flop synchroniser, consecutive-high debounce
// counter, single press event per physical press, and a set-dominant request latch.
module ped_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = traffic_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ped_btn,
  input  logic ped_clear,
  output logic pedestrian
);

  localparam int              DEB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             btn_s;
  logic [DEB_W-1:0] deb_cnt;
  logic             armed;
  logic             press_evt;

  // A press fires on the DEBOUNCE_CYCLES-th consecutive synced-high cycle, once per press.
  assign press_evt = armed && btn_s && (deb_cnt == DEB_LAST);

  // Bring the raw asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= ped_btn;
      btn_s   <= sync_q1;
    end
  end

  // Count consecutive synced-high cycles (saturating); re-arm only once the button is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_cnt <= '0;
      armed   <= 1'b1;
    end else if (!btn_s) begin
      deb_cnt <= '0;
      armed   <= 1'b1;
    end else begin
      if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
      if (press_evt) begin
        armed <= 1'b0;
      end
    end
  end

  // Latched request; a press coinciding with a clear wins so no request is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pedestrian <= 1'b0;
    end else if (press_evt) begin
      pedestrian <= 1'b1;
    end else if (ped_clear) begin
      pedestrian <= 1'b0;
    end
  end

endmodule : ped_debounce

// File: rtl/traffic_timer.sv
// Timebase for the traffic-light FSM: one-second and long-period strobes plus the
// conditioned pedestrian request.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int CYCLES_PER_SEC  = CLK_HZ,
  parameter int LONG_SECS       = traffic_pkg::LONG_SECS,
  parameter int DEBOUNCE_CYCLES = traffic_pkg::DEBOUNCE_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           reset_counter,
  input  logic                           ped_btn,
  input  logic                           ped_clear,
  output logic                           pulse_1s,
  output logic                           pulse_10s,
  output logic                           pedestrian,
  output logic [$clog2(LONG_SECS+1)-1:0] sec_count
);

  localparam int               CYC_W    = $clog2(CYCLES_PER_SEC);
  localparam int               SEC_W    = $clog2(LONG_SECS + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(LONG_SECS - 1);

  logic [CYC_W-1:0] cyc_cnt;

  // Prescaler and seconds counter; a restart request overrides a coincident wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt   <= '0;
      sec_count <= '0;
      pulse_1s  <= 1'b0;
      pulse_10s <= 1'b0;
    end else if (reset_counter) begin
      cyc_cnt   <= '0;
      sec_count <= '0;
      pulse_1s  <= 1'b0;
      pulse_10s <= 1'b0;
    end else if (cyc_cnt == CYC_LAST) begin
      cyc_cnt  <= '0;
      pulse_1s <= 1'b1;
      if (sec_count == SEC_LAST) begin
        sec_count <= '0;
        pulse_10s <= 1'b1;
      end else begin
        sec_count <= sec_count + SEC_W'(1);
        pulse_10s <= 1'b0;
      end
    end else begin
      cyc_cnt   <= cyc_cnt + CYC_W'(1);
      pulse_1s  <= 1'b0;
      pulse_10s <= 1'b0;
    end
  end

  ped_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ped_debounce (
    .clk        (clk),
    .rst        (rst),
    .ped_btn    (ped_btn),
    .ped_clear  (ped_clear),
    .pedestrian (pedestrian)
  );

endmodule : traffic_timer
